// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read/write port between the I-cache
// refill (requester 0) and the D-cache refill/write-through (requester 1).
// One transaction in flight, registered memory-side outputs, ready_mem watchdog.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        grant,
    output logic [1:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              re_mem,
    output logic              we_mem,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              ready_mem
);

    localparam int unsigned      WdogW   = $clog2(TIMEOUT);
    localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [WdogW-1:0]  wdog_q, wdog_d;
    logic [1:0]        grant_d, done_d;
    logic              err_d, re_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rdata_d;
    logic              owner;

    // Requester 0 only reads, so its write-enable bit is never consulted.
    logic unused_req_we0;
    assign unused_req_we0 = req_we[0];

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        wdog_d   = wdog_q;
        grant_d  = grant;
        done_d   = done;
        err_d    = err;
        re_d     = re_mem;
        we_d     = we_mem;
        addr_d   = mem_addr;
        wdata_d  = mem_wdata;
        rdata_d  = rdata;
        // Both requesting: rr_ptr decides; otherwise the lone requester wins.
        owner    = (req == 2'b11) ? rr_ptr_q : req[1];

        unique case (state_q)
            StIdle: begin
                if (req != 2'b00) begin
                    grant_d = owner ? 2'b10 : 2'b01;
                    addr_d  = owner ? req_addr1 : req_addr0;
                    wdata_d = req_wdata1;
                    we_d    = owner & req_we[1];
                    re_d    = ~(owner & req_we[1]);
                    wdog_d  = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (ready_mem) begin
                    if (re_mem) begin
                        rdata_d = mem_rdata;
                    end
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    done_d  = grant;
                    state_d = StDone;
                end else if (wdog_q == WdogMax) begin
                    // Memory never answered: abort, rdata keeps its old value.
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    done_d  = grant;
                    state_d = StDone;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StDone: begin
                // Point the tie-breaker at whoever did not just finish.
                rr_ptr_d = ~grant[1];
                grant_d  = 2'b00;
                done_d   = 2'b00;
                err_d    = 1'b0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs, asynchronously cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rr_ptr_q  <= 1'b0;
            wdog_q    <= '0;
            grant     <= 2'b00;
            done      <= 2'b00;
            err       <= 1'b0;
            re_mem    <= 1'b0;
            we_mem    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            wdog_q    <= wdog_d;
            grant     <= grant_d;
            done      <= done_d;
            err       <= err_d;
            re_mem    <= re_d;
            we_mem    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            rdata     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 64;

    logic          clk;
    logic          reset;
    logic [1:0]    req, req_we;
    logic [AW-1:0] req_addr0, req_addr1;
    logic [DW-1:0] req_wdata1;
    logic [1:0]    grant, done;
    logic          err;
    logic [DW-1:0] rdata;
    logic          re_mem, we_mem;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          ready_mem;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr0 (req_addr0),
        .req_addr1 (req_addr1),
        .req_wdata1(req_wdata1),
        .grant     (grant),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .re_mem    (re_mem),
        .we_mem    (we_mem),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .ready_mem (ready_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: is a transaction open, who owns it, how long it
    // has waited for memory, and whether it is in its completion cycle.
    bit          m_act, m_fin, m_err, m_wr, m_last;
    int          m_own, m_wait;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_act = 0; m_fin = 0; m_err = 0; m_wr = 0;
        m_last = 1;  // rr pointer starts at requester 0
        m_own = 0; m_wait = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_step();
        if (m_fin) begin
            m_act = 0; m_fin = 0; m_err = 0; m_last = m_own[0];
        end else if (m_act) begin
            if (ready_mem) begin
                m_fin = 1;
                if (!m_wr) m_rdata = mem_rdata;
            end else if (m_wait == TO - 1) begin
                m_fin = 1; m_err = 1;
            end else begin
                m_wait++;
            end
        end else if (req != 2'b00) begin
            if (req == 2'b11) m_own = m_last ? 0 : 1;
            else              m_own = req[1] ? 1 : 0;
            m_act   = 1;
            m_wait  = 0;
            m_wr    = (m_own == 1) && req_we[1];
            m_addr  = (m_own == 1) ? req_addr1 : req_addr0;
            m_wdata = req_wdata1;
        end
    endtask

    // Model advances on each rising edge; outputs compared on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) model_reset();
            else model_step();
            @(negedge clk);
            check("grant",     64'(grant),     m_act ? 64'(1 << m_own) : 64'd0);
            check("done",      64'(done),      m_fin ? 64'(1 << m_own) : 64'd0);
            check("err",       64'(err),       64'(m_fin && m_err));
            check("re_mem",    64'(re_mem),    64'(m_act && !m_fin && !m_wr));
            check("we_mem",    64'(we_mem),    64'(m_act && !m_fin && m_wr));
            check("mem_addr",  64'(mem_addr),  64'(m_addr));
            check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            check("rdata",     64'(rdata),     64'(m_rdata));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] seen [$];
        int         n;
        int         ndone;
        int         ready_pct;

        reset = 1'b1;
        model_reset();
        req = 2'b00; req_we = 2'b00;
        req_addr0 = '0; req_addr1 = '0; req_wdata1 = '0;
        mem_rdata = '0; ready_mem = 1'b0;
        #1;
        check("reset_grant",  64'(grant),  64'd0);
        check("reset_re",     64'(re_mem), 64'd0);
        check("reset_rdata",  64'(rdata),  64'd0);
        check("reset_addr",   64'(mem_addr), 64'd0);
        tick();
        reset = 1'b0;

        // Single read from requester 0, memory answers after 3 strobe cycles.
        req = 2'b01; req_addr0 = 32'h40;
        tick();
        check("rd_grant", 64'(grant), 64'h1);
        check("rd_re",    64'(re_mem), 64'h1);
        check("rd_addr",  64'(mem_addr), 64'h40);
        repeat (2) begin
            tick();
            check("rd_re_hold", 64'(re_mem), 64'h1);
        end
        ready_mem = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        check("rd_done",  64'(done),  64'h1);
        check("rd_rdata", 64'(rdata), 64'hDEADBEEF);
        check("rd_re_off", 64'(re_mem), 64'h0);
        req = 2'b00; ready_mem = 1'b0;
        tick();
        check("rd_done_off", 64'(done),  64'h0);
        check("rd_idle",     64'(grant), 64'h0);

        // Write from requester 1.
        req = 2'b10; req_we = 2'b10; req_addr1 = 32'h80; req_wdata1 = 32'h1234;
        tick();
        check("wr_we",    64'(we_mem),    64'h1);
        check("wr_re",    64'(re_mem),    64'h0);
        check("wr_addr",  64'(mem_addr),  64'h80);
        check("wr_wdata", 64'(mem_wdata), 64'h1234);
        tick();
        check("wr_we_hold", 64'(we_mem), 64'h1);
        ready_mem = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        check("wr_done",  64'(done),  64'h2);
        check("wr_rdata", 64'(rdata), 64'hDEADBEEF);
        req = 2'b00; req_we = 2'b00; ready_mem = 1'b0;
        tick();

        // Both requesting from reset with immediate ready: grants alternate.
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        req = 2'b11; ready_mem = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (grant != 2'b00 && done == 2'b00) seen.push_back(grant);
            if (done != 2'b00) ndone++;
        end
        check("alt_count", 64'(seen.size()), 64'd4);
        for (int i = 0; i < seen.size() && i < 4; i++)
            check("alt_grant", 64'(seen[i]), (i % 2 == 0) ? 64'h1 : 64'h2);
        check("alt_dones", 64'(ndone), 64'd4);
        req = 2'b00; ready_mem = 1'b0;
        tick();

        // Memory never answers: abort after TIMEOUT strobe cycles.
        req = 2'b01;
        tick();
        n = 0;
        while (re_mem === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check("to_re_cycles", 64'(n),    64'd64);
        check("to_done",      64'(done), 64'h1);
        check("to_err",       64'(err),  64'h1);
        req = 2'b00;
        tick();
        check("to_err_off", 64'(err),   64'h0);
        check("to_idle",    64'(grant), 64'h0);

        // Asynchronous reset between edges while a transaction is open.
        req = 2'b10;
        tick();
        check("ar_grant_pre", 64'(grant), 64'h2);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("ar_re",    64'(re_mem), 64'h0);
        check("ar_we",    64'(we_mem), 64'h0);
        check("ar_grant", 64'(grant),  64'h0);
        tick();
        reset = 1'b0;
        tick();
        check("ar_first_grant", 64'(grant), 64'h2);
        ready_mem = 1'b1;
        tick();
        check("ar_done", 64'(done), 64'h2);
        req = 2'b00; ready_mem = 1'b0;
        tick();

        // req dropped mid-transaction, then a stray ready_mem while idle.
        req = 2'b01; req_addr0 = 32'hC0;
        tick();
        req = 2'b00;
        tick();
        check("drop_re", 64'(re_mem), 64'h1);
        ready_mem = 1'b1;
        tick();
        check("drop_done", 64'(done), 64'h1);
        tick();
        repeat (2) begin
            tick();
            check("stray_grant", 64'(grant),  64'h0);
            check("stray_re",    64'(re_mem), 64'h0);
            check("stray_done",  64'(done),   64'h0);
        end
        ready_mem = 1'b0;

        // Randomized traffic, including occasional mid-cycle resets.
        ready_pct = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ready_pct = 4;
                    1:       ready_pct = 30;
                    default: ready_pct = 90;
                endcase
            end
            req        = 2'($urandom_range(0, 3));
            req_we     = 2'($urandom_range(0, 3));
            req_addr0  = $urandom;
            req_addr1  = $urandom;
            req_wdata1 = $urandom;
            mem_rdata  = $urandom;
            ready_mem  = ($urandom_range(0, 99) < ready_pct);
            if ($urandom_range(0, 399) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
